// File: rtl/alu_op_issue.sv
// alu_op_issue
// Execute-stage front end for the combinational ALU. Decodes ALUOp/Funct3/
// Funct7 into the ALU Operation code, selects operand B (register or
// immediate) and registers the result behind a valid/ready handshake with a
// one-entry skid buffer so downstream stalls never drop an instruction.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ready is purely registered
//   ALUOp, Funct3, Funct7, ALUSrc   decode inputs
//   RD1, RD2, Imm     register operands and sign-extended immediate
//   flush             synchronous pipeline flush, highest priority
//   out_valid/out_ready downstream handshake
//   SrcA, SrcB, Operation, illegal  registered entry toward the ALU
module alu_op_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     ALUSrc,
    input  logic [DATA_WIDTH-1:0]    RD1,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    // Decode result packed as {illegal, shift, op[3:0]}.
    function automatic logic [5:0] decode_op(
        input logic [1:0] aluop,
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       alusrc
    );
        logic [5:0] res;
        res = 6'b00_0000;
        case (aluop)
            2'b00: res = 6'b00_0010;
            2'b01: begin
                case (f3)
                    3'b000:  res = 6'b00_1000;
                    3'b001:  res = 6'b00_1011;
                    3'b100:  res = 6'b00_1001;
                    3'b101:  res = 6'b00_1010;
                    default: res = 6'b10_0000;
                endcase
            end
            2'b10: begin
                case (f3)
                    // Immediate forms have no SUB; Funct7 bits there are imm.
                    3'b000:  res = (f7b5 && !alusrc) ? 6'b00_0110 : 6'b00_0010;
                    3'b111:  res = 6'b00_0000;
                    3'b110:  res = 6'b00_0001;
                    3'b100:  res = 6'b00_0011;
                    3'b001:  res = 6'b01_0100;
                    3'b101:  res = f7b5 ? 6'b01_0111 : 6'b01_0101;
                    default: res = 6'b10_0000;
                endcase
            end
            default: res = 6'b10_0000;
        endcase
        return res;
    endfunction

    logic [5:0]               w_dec;
    logic [DATA_WIDTH-1:0]    w_srcb_raw;
    logic [DATA_WIDTH-1:0]    w_srcb;
    logic                     w_in_xfer;
    logic                     w_out_xfer;

    state_t                   r_state;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_srca;
    logic [DATA_WIDTH-1:0]    r_srcb;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic                     r_illegal;
    logic [DATA_WIDTH-1:0]    r_skid_srca;
    logic [DATA_WIDTH-1:0]    r_skid_srcb;
    logic [OPCODE_LENGTH-1:0] r_skid_op;
    logic                     r_skid_illegal;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Decode and operand-B selection; shifts only use the low 5 bits of B.
    always_comb begin
        w_dec      = decode_op(ALUOp, Funct3, Funct7[5], ALUSrc);
        w_srcb_raw = ALUSrc ? Imm : RD2;
        if (w_dec[4]) begin
            w_srcb = {{(DATA_WIDTH-5){1'b0}}, w_srcb_raw[4:0]};
        end else begin
            w_srcb = w_srcb_raw;
        end
    end

    // Issue FSM: output register, skid register and registered handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_EMPTY;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_srca         <= '0;
            r_srcb         <= '0;
            r_op           <= '0;
            r_illegal      <= 1'b0;
            r_skid_srca    <= '0;
            r_skid_srcb    <= '0;
            r_skid_op      <= '0;
            r_skid_illegal <= 1'b0;
        end else if (flush) begin
            // Flush wins over every transfer; any incoming entry is dropped.
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_srca      <= RD1;
                        r_srcb      <= w_srcb;
                        r_op        <= OPCODE_LENGTH'(w_dec[3:0]);
                        r_illegal   <= w_dec[5];
                        r_out_valid <= 1'b1;
                        r_state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_srca    <= RD1;
                        r_srcb    <= w_srcb;
                        r_op      <= OPCODE_LENGTH'(w_dec[3:0]);
                        r_illegal <= w_dec[5];
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else if (w_in_xfer) begin
                        // Output is stalled: park the new entry in the skid.
                        r_skid_srca    <= RD1;
                        r_skid_srcb    <= w_srcb;
                        r_skid_op      <= OPCODE_LENGTH'(w_dec[3:0]);
                        r_skid_illegal <= w_dec[5];
                        r_in_ready     <= 1'b0;
                        r_state        <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        r_srca     <= r_skid_srca;
                        r_srcb     <= r_skid_srcb;
                        r_op       <= r_skid_op;
                        r_illegal  <= r_skid_illegal;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_FULL;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign SrcA      = r_srca;
    assign SrcB      = r_srcb;
    assign Operation = r_op;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue.
module tb_alu_op_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        ALUSrc;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] Imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        illegal;

    int checks;
    int errors;

    // {out_valid, illegal, Operation, SrcA, SrcB}
    logic [69:0] obs;
    assign obs = {out_valid, illegal, Operation, SrcA, SrcB};

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .ALUSrc(ALUSrc),
        .RD1(RD1), .RD2(RD2), .Imm(Imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic src, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        ALUOp = op; Funct3 = f3; Funct7 = f7; ALUSrc = src; RD1 = a; RD2 = b; Imm = im;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        drive(2'b10, 3'b000, 7'd0, 1'b0, 32'd5, 32'd7, 32'd0);
        tick(); tick();
        checks++;
        if (obs !== {1'b0, 1'b0, 4'b0000, 32'd0, 32'd0}) begin
            errors++; $display("FAIL reset_outputs got %h want %h", obs, {1'b0, 1'b0, 4'b0000, 32'd0, 32'd0});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk); reset = 1'b1;
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 4'b0010, 32'd5, 32'd7}) begin
            errors++; $display("FAIL first_add got %h want %h", obs, {1'b1, 1'b0, 4'b0010, 32'd5, 32'd7});
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL first_drain got %b want 0", out_valid);
        end
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        src;
        logic [31:0] b;
        logic [31:0] im;
        logic        e_ill;
        logic [3:0]  e_op;
        logic [31:0] e_b;
    } vec_t;

    task automatic test_decode();
        vec_t v [15];
        v[0]  = '{2'b10, 3'b000, 7'b0100000, 1'b0, 32'd30, 32'd9, 1'b0, 4'b0110, 32'd30};
        v[1]  = '{2'b10, 3'b000, 7'b0100000, 1'b1, 32'd30, 32'd9, 1'b0, 4'b0010, 32'd9};
        v[2]  = '{2'b10, 3'b101, 7'b0100000, 1'b1, 32'd1, 32'hFFFFFFE3, 1'b0, 4'b0111, 32'h3};
        v[3]  = '{2'b01, 3'b001, 7'd0, 1'b0, 32'd77, 32'd0, 1'b0, 4'b1011, 32'd77};
        v[4]  = '{2'b10, 3'b101, 7'd0, 1'b0, 32'h12345678, 32'd0, 1'b0, 4'b0101, 32'h18};
        v[5]  = '{2'b10, 3'b001, 7'd0, 1'b1, 32'd0, 32'hFFFFFF25, 1'b0, 4'b0100, 32'h5};
        v[6]  = '{2'b01, 3'b000, 7'd0, 1'b0, 32'd11, 32'd0, 1'b0, 4'b1000, 32'd11};
        v[7]  = '{2'b01, 3'b100, 7'd0, 1'b0, 32'd12, 32'd0, 1'b0, 4'b1001, 32'd12};
        v[8]  = '{2'b01, 3'b101, 7'd0, 1'b0, 32'd13, 32'd0, 1'b0, 4'b1010, 32'd13};
        v[9]  = '{2'b10, 3'b111, 7'd0, 1'b0, 32'hF0F0, 32'd0, 1'b0, 4'b0000, 32'hF0F0};
        v[10] = '{2'b10, 3'b110, 7'd0, 1'b0, 32'd14, 32'd0, 1'b0, 4'b0001, 32'd14};
        v[11] = '{2'b10, 3'b100, 7'd0, 1'b1, 32'd0, 32'hABCD0000, 1'b0, 4'b0011, 32'hABCD0000};
        v[12] = '{2'b00, 3'b011, 7'b0100000, 1'b1, 32'd0, 32'hFFFFFFFC, 1'b0, 4'b0010, 32'hFFFFFFFC};
        v[13] = '{2'b11, 3'b000, 7'd0, 1'b0, 32'd21, 32'd0, 1'b1, 4'b0000, 32'd21};
        v[14] = '{2'b10, 3'b010, 7'd0, 1'b0, 32'd22, 32'd0, 1'b1, 4'b0000, 32'd22};
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(v[i].op, v[i].f3, v[i].f7, v[i].src, 32'h1000 + 32'(i), v[i].b, v[i].im);
            in_valid = 1'b1;
            tick();
            checks++;
            if (obs !== {1'b1, v[i].e_ill, v[i].e_op, 32'h1000 + 32'(i), v[i].e_b}) begin
                errors++;
                $display("FAIL decode_%0d got %h want %h", i, obs,
                         {1'b1, v[i].e_ill, v[i].e_op, 32'h1000 + 32'(i), v[i].e_b});
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(2'b10, 3'b000, 7'd0, 1'b0, 32'hA1, 32'hA2, 32'd0);
        in_valid = 1'b1;
        tick();
        drive(2'b10, 3'b100, 7'd0, 1'b0, 32'hB1, 32'hB2, 32'd0);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({obs, in_ready} !== {1'b1, 1'b0, 4'b0010, 32'hA1, 32'hA2, 1'b0}) begin
            errors++; $display("FAIL bp_hold_a got %h/%b want A with in_ready 0", obs, in_ready);
        end
        tick();
        checks++;
        if ({obs, in_ready} !== {1'b1, 1'b0, 4'b0010, 32'hA1, 32'hA2, 1'b0}) begin
            errors++; $display("FAIL bp_stable got %h/%b want A with in_ready 0", obs, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({obs, in_ready} !== {1'b1, 1'b0, 4'b0011, 32'hB1, 32'hB2, 1'b1}) begin
            errors++; $display("FAIL bp_then_b got %h/%b want B with in_ready 1", obs, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'd0, 1'b0, 32'hC1, 32'hC2, 32'd0);
        in_valid = 1'b1;
        tick();
        drive(2'b00, 3'b000, 7'd0, 1'b0, 32'hD1, 32'hD2, 32'd0);
        tick();
        drive(2'b00, 3'b000, 7'd0, 1'b0, 32'hE1, 32'hE2, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_empty got %b%b want 01", out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_discard got out_valid %b SrcA %h want 0", out_valid, SrcA);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(2'b10, 3'b000, 7'd0, 1'b0, 32'(i * 3 + 1), 32'(i), 32'd0);
            in_valid = 1'b1;
            tick();
            checks++;
            if ({obs, in_ready} !== {1'b1, 1'b0, 4'b0010, 32'(i * 3 + 1), 32'(i), 1'b1}) begin
                errors++; $display("FAIL stream_%0d got %h/%b want SrcA %0d", i, obs, in_ready, i * 3 + 1);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'd0, 1'b0, 32'hF1, 32'hF2, 32'd0);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({obs, in_ready} !== {70'd0, 1'b1}) begin
            errors++; $display("FAIL async_reset got %h/%b want zeros/1", obs, in_ready);
        end
        @(negedge clk); reset = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_lost_entry got %b want 0", out_valid);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_streaming();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Execute-stage front end that drives the ALU's Operation/SrcA/SrcB interface.
- Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code and selects operand B (register or immediate).
- Registers the result with a valid/ready handshake and a one-entry skid buffer, so stalls from downstream never drop an instruction.
- Sits between the ID stage register file read and the combinational ALU.

Parameters:
DATA_WIDTH, 32, operand width
OPCODE_LENGTH, 4, ALU Operation code width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept an instruction this cycle
ALUOp  input  2  main-decoder class: 00 mem/addr, 01 branch, 10 R/I arith, 11 reserved
Funct3  input  3  instruction funct3
Funct7  input  7  instruction funct7
ALUSrc  input  1  1 = operand B from Imm, 0 = from RD2
RD1  input  DATA_WIDTH  register operand A
RD2  input  DATA_WIDTH  register operand B
Imm  input  DATA_WIDTH  sign-extended immediate
flush  input  1  synchronous pipeline flush (branch mispredict)
out_valid  output  1  SrcA/SrcB/Operation valid toward ALU
out_ready  input  1  downstream accepts this cycle
SrcA  output  DATA_WIDTH  ALU operand A
SrcB  output  DATA_WIDTH  ALU operand B
Operation  output  OPCODE_LENGTH  ALU operation code
illegal  output  1  registered with the entry: decode not supported

Behaviour:
- Reset (reset=0, async): out_valid=0, SrcA=SrcB=0, Operation=0000, illegal=0, skid empty, in_ready=1.
- in_ready = skid buffer empty (registered state, no combinational path from out_ready).
- Input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- Latency: accepted instruction appears on outputs the next cycle when output is empty or drains that cycle.
- States:
  - EMPTY: out_valid=0. Input transfer -> FULL.
  - FULL: out_valid=1.
    - Input+output transfer -> FULL with new entry.
    - Output transfer only -> EMPTY.
    - Input only (out_ready=0) -> SKID; new entry held in skid, outputs unchanged.
  - SKID: out_valid=1, in_ready=0. Output transfer -> skid moves to output, FULL.
- Outputs are stable while out_valid=1 and out_ready=0.
- Decode (Operation):
  - ALUOp 00 -> 0010 ADD.
  - ALUOp 01, by Funct3: 000 -> 1000 BEQ; 001 -> 1011 BNE; 100 -> 1001 BLT; 101 -> 1010 BGE; others illegal.
  - ALUOp 10, by Funct3:
    - 000: SUB 0110 if Funct7[5]=1 and ALUSrc=0, else ADD 0010.
    - 111 -> 0000 AND; 110 -> 0001 OR; 100 -> 0011 XOR; 001 -> 0100 SLL.
    - 101: SRA 0111 if Funct7[5]=1, else SRL 0101.
    - 010/011 (SLT/SLTU) illegal.
  - ALUOp 11 illegal.
  - Illegal: Operation=0000, illegal=1, entry still flows; the trap is handled downstream.
- SrcA = RD1. SrcB = ALUSrc ? Imm : RD2.
- For SLL/SRL/SRA, SrcB is forced to zero-extended SrcB[4:0]; upper bits are 0.
- flush=1: at the next edge, out_valid=0 and skid emptied (state EMPTY).
  - Any in_valid that cycle is discarded, whatever in_ready is.
  - Flush has priority over all transfers.
- Reset asserted mid-operation: immediate return to reset values; in-flight entries are lost.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> out_valid=0, Operation=0000, in_ready=1; release, issue ADD RD1=5 RD2=7 ALUOp=10 F3=000 F7=0 -> next cycle SrcA=5, SrcB=7, Operation=0010.
- Decode sweep: ALUOp=10 F3=000 F7=0100000 ALUSrc=0 -> 0110; same with ALUSrc=1 -> 0010; F3=101 F7=0100000 Imm=0xFFFFFFE3 -> Operation 0111, SrcB=0x00000003; ALUOp=01 F3=001 -> 1011.
- Illegal: ALUOp=11, and ALUOp=10 F3=010 -> illegal=1, Operation=0000, out_valid=1.
- Backpressure: out_ready=0, send A then B -> outputs hold A, B in skid, in_ready=0; raise out_ready -> A, then B, in order, no loss or duplicate.
- Flush in SKID state with in_valid=1 -> next cycle out_valid=0, in_ready=1; the discarded instruction never appears.
- Streaming: in_valid=out_ready=1 for 8 cycles -> one output per cycle, order preserved, in_ready stays 1.
